// File: rtl/dl11_rx_pkg.sv
// Shared types and constants for the DL11 console receiver.
package dl11_pkg;

  // Receiver FSM states; encoding is fixed so it can be probed in the field.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } dl11_state_e;

  // 326 clocks per 16x tick gives 9600 baud from a 50 MHz clock.
  localparam int DL11_DIV_DEFAULT = 326;

  // Receive buffer depth in characters.
  localparam int DL11_FIFO_DEPTH = 4;

endpackage

// File: rtl/rx_fifo4.sv
// 4-entry x 9-bit synchronous FIFO holding {ferr, data} characters.
// A push into a full FIFO is accepted only if a pop frees a slot in the same cycle.
module rx_fifo4
  import dl11_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full
);

  logic [8:0] r_mem [DL11_FIFO_DEPTH];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign empty  = (r_count == 3'd0);
  assign full   = (r_count == 3'(DL11_FIFO_DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Head entry is read straight out of the storage registers.
  assign dout = r_mem[r_rd_ptr];

  // Storage: cleared on reset so the head reads as zero when empty after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DL11_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; 2-bit pointers wrap naturally at depth 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dl11_rx.sv
// DL11 console receiver: line synchroniser, 16x tick divider, 8N1 deserialiser
// and a 4-character receive FIFO with framing-error and overrun reporting.
module dl11_rx
  import dl11_pkg::*;
#(
  parameter int DIVISOR = DL11_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs232_rx,
  input  logic       rx_rd,
  input  logic       rx_clr,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  output logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_active
);

  logic        r_sync1;
  logic        r_sync2;
  logic        w_rxs;
  logic [15:0] r_div_cnt;
  logic        w_tick;

  dl11_state_e r_state;
  dl11_state_e w_state_next;
  logic [3:0]  r_sc;
  logic [3:0]  w_sc_next;
  logic [2:0]  r_bc;
  logic [2:0]  w_bc_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        r_push;
  logic        w_push_next;
  logic        r_push_ferr;
  logic        w_ferr_next;

  logic [8:0]  w_fifo_dout;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_overrun_evt;

  // Two-flop synchroniser; resets to the idle (mark) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Free-running oversample divider; never realigned to the start edge.
  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  assign w_tick = (r_div_cnt == 16'(DIVISOR - 1));

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sc        <= '0;
      r_bc        <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_ferr <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sc        <= w_sc_next;
      r_bc        <= w_bc_next;
      r_shift     <= w_shift_next;
      r_push      <= w_push_next;
      r_push_ferr <= w_ferr_next;
    end
  end

  // Next-state logic: start qualification at mid start bit, then one sample
  // every 16 ticks for eight data bits and the stop bit.
  always_comb begin
    w_state_next = r_state;
    w_sc_next    = r_sc;
    w_bc_next    = r_bc;
    w_shift_next = r_shift;
    w_push_next  = 1'b0;
    w_ferr_next  = r_push_ferr;
    case (r_state)
      IDLE: begin
        if (w_tick && !w_rxs) begin
          w_state_next = START;
          w_sc_next    = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_sc == 4'd7) begin
            w_sc_next = '0;
            if (!w_rxs) begin
              w_state_next = DATA;
              w_bc_next    = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_sc_next = r_sc + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_sc == 4'd15) begin
            w_sc_next          = '0;
            w_shift_next[r_bc] = w_rxs;
            if (r_bc == 3'd7) begin
              w_state_next = STOP;
            end else begin
              w_bc_next = r_bc + 3'd1;
            end
          end else begin
            w_sc_next = r_sc + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_sc == 4'd15) begin
            w_sc_next    = '0;
            w_push_next  = 1'b1;
            w_ferr_next  = !w_rxs;
            w_state_next = w_rxs ? IDLE : WAITHI;
          end else begin
            w_sc_next = r_sc + 4'd1;
          end
        end
      end
      WAITHI: begin
        // Hold off through a break until the line returns to mark.
        if (w_tick && w_rxs) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  rx_fifo4 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_push),
    .pop   (rx_rd),
    .din   ({r_push_ferr, r_shift}),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  // A pop in the same cycle frees the slot, so only a push against a full,
  // unread FIFO is an overrun.
  assign w_overrun_evt = r_push && w_fifo_full && !rx_rd;

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun <= 1'b0;
    end else if (w_overrun_evt) begin
      rx_overrun <= 1'b1;
    end else if (rx_clr) begin
      rx_overrun <= 1'b0;
    end
  end

  assign rx_data   = w_fifo_dout[7:0];
  assign rx_ferr   = w_fifo_dout[8];
  assign rx_ready  = !w_fifo_empty;
  assign rx_active = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule

// File: tb/tb_dl11_rx.sv
// Directed testbench for dl11_rx at DIVISOR=4 (64 clocks per bit).
module tb_dl11_rx;

  localparam int DIV    = 4;
  localparam int BITCLK = 16 * DIV;
  localparam int CHRCLK = 10 * BITCLK;

  logic       clk = 1'b0;
  logic       reset;
  logic       rs232_rx;
  logic       rx_rd;
  logic       rx_clr;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dl11_rx #(.DIVISOR(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs232_rx   (rs232_rx),
    .rx_rd      (rx_rd),
    .rx_clr     (rx_clr),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .rx_active  (rx_active)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame, LSB first; called and returns on a falling edge.
  task automatic send_char(input logic [7:0] d, input logic stop_bit);
    rs232_rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    rs232_rx = stop_bit;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!rx_ready && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check(name, rx_ready, 1'b1);
  endtask

  // Absolute time bound so a stuck design still ends the run.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h7E, 1'b0, 8'h7E, 1'b1};
    vecs[5] = '{8'hC3, 1'b1, 8'hC3, 1'b0};

    reset    = 1'b1;
    rs232_rx = 1'b1;
    rx_rd    = 1'b0;
    rx_clr   = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_ready", rx_ready, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_ferr", rx_ferr, 1'b0);
    check("reset_overrun", rx_overrun, 1'b0);
    check("reset_active", rx_active, 1'b0);
    reset = 1'b0;
    repeat (BITCLK) @(negedge clk);

    // Table-driven single characters: receive, check head, pop, check empty.
    for (int v = 0; v < 6; v++) begin
      send_char(vecs[v].data, vecs[v].stop_bit);
      rs232_rx = 1'b1;
      wait_ready("vec_ready");
      check("vec_data", rx_data, vecs[v].exp_data);
      check("vec_ferr", rx_ferr, vecs[v].exp_ferr);
      $display("vec %0d: sent %02h stop=%0b -> data=%02h ferr=%0b",
               v, vecs[v].data, vecs[v].stop_bit, rx_data, rx_ferr);
      pop();
      check("vec_pop_empty", rx_ready, 1'b0);
      repeat (BITCLK) @(negedge clk);
    end

    // Short low glitch (5 ticks): start is detected, then rejected.
    rs232_rx = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_active", rx_active, 1'b1);
    repeat (8) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (80) @(negedge clk);
    check("glitch_idle", rx_active, 1'b0);
    check("glitch_nopush", rx_ready, 1'b0);
    $display("glitch: 20-clock low pulse -> active=%0b ready=%0b", rx_active, rx_ready);

    // Break: 0xA3 with low stop bit, line held low for 3 more characters.
    send_char(8'hA3, 1'b0);
    repeat (3 * CHRCLK) @(negedge clk);
    check("break_ready", rx_ready, 1'b1);
    check("break_data", rx_data, 8'hA3);
    check("break_ferr", rx_ferr, 1'b1);
    check("break_waithi_inactive", rx_active, 1'b0);
    pop();
    check("break_one_entry", rx_ready, 1'b0);
    repeat (CHRCLK) @(negedge clk);
    check("break_still_empty", rx_ready, 1'b0);
    rs232_rx = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    check("break_release_empty", rx_ready, 1'b0);
    check("break_release_idle", rx_active, 1'b0);
    $display("break: one entry {ferr=1, A3}, none after release");

    // Overrun: five characters into a four-entry FIFO with no reads.
    for (int i = 1; i <= 5; i++) begin
      send_char(8'(i), 1'b1);
    end
    check("ovr_flag", rx_overrun, 1'b1);
    check("ovr_ready", rx_ready, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_data", rx_data, 8'(i));
      check("ovr_ferr", rx_ferr, 1'b0);
      $display("overrun read %0d: data=%02h", i, rx_data);
      pop();
    end
    check("ovr_drained", rx_ready, 1'b0);
    check("ovr_sticky", rx_overrun, 1'b1);
    pop();
    check("ovr_empty_pop", rx_ready, 1'b0);
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    check("ovr_cleared", rx_overrun, 1'b0);

    // Measure start-to-ready latency on the first character; later frames
    // start a multiple of the tick period apart so the latency repeats.
    k = 0;
    fork
      send_char(8'h01, 1'b1);
      begin
        while (!rx_ready && k < 1000) begin
          @(negedge clk);
          k++;
        end
      end
    join
    check("sim_latency_found", (k >= 3 && k < 700) ? 1'b1 : 1'b0, 1'b1);
    if (k < 3) k = 3;
    send_char(8'h02, 1'b1);
    send_char(8'h03, 1'b1);
    send_char(8'h04, 1'b1);
    // Fifth character: pop lands on the same edge as the push into a full FIFO.
    fork
      send_char(8'h05, 1'b1);
      begin
        repeat (k - 2) @(negedge clk);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
      end
    join
    check("sim_no_overrun", rx_overrun, 1'b0);
    check("sim_ready", rx_ready, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      check("sim_data", rx_data, 8'(i));
      $display("simultaneous read: data=%02h", rx_data);
      pop();
    end
    check("sim_drained", rx_ready, 1'b0);

    // Reset during data bit 4 of 0xFF, with one unread character buffered.
    send_char(8'h5A, 1'b1);
    wait_ready("rst_pre_ready");
    rs232_rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (4 * BITCLK + BITCLK / 2) @(negedge clk);
    reset = 1'b1;
    rx_rd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_rd = 1'b0;
    check("rst_ready", rx_ready, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", rx_ferr, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_active", rx_active, 1'b0);
    repeat (5 * BITCLK) @(negedge clk);
    check("rst_nopush", rx_ready, 1'b0);
    send_char(8'h3C, 1'b1);
    wait_ready("rst_after_ready");
    check("rst_after_data", rx_data, 8'h3C);
    check("rst_after_ferr", rx_ferr, 1'b0);
    $display("reset mid-frame: next char data=%02h ferr=%0b", rx_data, rx_ferr);
    pop();
    check("rst_after_empty", rx_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
